// File: rtl/bingo_map_builder.sv
// Board-entry stage: collects 25 two-digit numbers from the keypad and
// packs the accepted, distinct 1..25 values into the board map.
module bingo_map_builder #(
    parameter int CELLS = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel_start,
    input  logic [3:0]           one_num,
    input  logic                 enter_pulse,
    output logic [5*CELLS-1:0]   map,
    output logic [4:0]           cell_idx,
    output logic                 tens_held,
    output logic                 sel_err,
    output logic                 sel_done
);

    typedef enum logic [2:0] {
        IDLE,
        TENS,
        UNITS,
        CHECK,
        DONE
    } state_t;

    state_t             state_q;
    logic [5*CELLS-1:0] map_q;
    logic [CELLS-1:0]   used_q;
    logic [4:0]         cell_idx_q;
    logic [3:0]         tens_q;
    logic [6:0]         num_q;
    logic               tens_held_q;
    logic               sel_err_q;
    logic               sel_done_q;

    logic [6:0]         num_d;
    logic [4:0]         used_idx;
    logic [31:0]        used_ext;
    logic               in_range;
    logic               num_ok;
    logic               digit_ok;

    always_comb begin
        num_d    = {3'b000, tens_q} * 7'd10 + {3'b000, one_num};
        digit_ok = (one_num <= 4'd9);
        used_idx = num_q[4:0] - 5'd1;
        // Padded so an out-of-range number never indexes past the mask
        used_ext = {{(32 - CELLS){1'b0}}, used_q};
        in_range = (num_q >= 7'd1) && (num_q <= 7'(CELLS));
        num_ok   = in_range && !used_ext[used_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            map_q       <= '0;
            used_q      <= '0;
            cell_idx_q  <= '0;
            tens_q      <= '0;
            num_q       <= '0;
            tens_held_q <= 1'b0;
            sel_err_q   <= 1'b0;
            sel_done_q  <= 1'b0;
        end else begin
            sel_err_q <= 1'b0;
            if (sel_start) begin
                map_q       <= '0;
                used_q      <= '0;
                cell_idx_q  <= '0;
                tens_q      <= '0;
                tens_held_q <= 1'b0;
                sel_done_q  <= 1'b0;
                state_q     <= TENS;
            end else begin
                unique case (state_q)
                    TENS: begin
                        if (enter_pulse) begin
                            if (digit_ok) begin
                                tens_q      <= one_num;
                                tens_held_q <= 1'b1;
                                state_q     <= UNITS;
                            end else begin
                                sel_err_q <= 1'b1;
                            end
                        end
                    end
                    UNITS: begin
                        if (enter_pulse) begin
                            if (digit_ok) begin
                                num_q       <= num_d;
                                tens_held_q <= 1'b0;
                                state_q     <= CHECK;
                            end else begin
                                sel_err_q <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        if (num_ok) begin
                            map_q[5*int'(cell_idx_q) +: 5] <= num_q[4:0];
                            used_q[used_idx] <= 1'b1;
                            cell_idx_q       <= cell_idx_q + 5'd1;
                            if (cell_idx_q == 5'(CELLS - 1)) begin
                                sel_done_q <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                state_q <= TENS;
                            end
                        end else begin
                            sel_err_q <= 1'b1;
                            state_q   <= TENS;
                        end
                    end
                    IDLE, DONE: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign map       = map_q;
    assign cell_idx  = cell_idx_q;
    assign tens_held = tens_held_q;
    assign sel_err   = sel_err_q;
    assign sel_done  = sel_done_q;

endmodule

// File: tb/tb_bingo_map_builder.sv
// Scoreboard bench for bingo_map_builder: a board model predicts each
// number's outcome, which is queued and compared when the DUT responds.
module tb_bingo_map_builder;

    logic         clk;
    logic         rst;
    logic         sel_start;
    logic [3:0]   one_num;
    logic         enter_pulse;
    logic [124:0] map;
    logic [4:0]   cell_idx;
    logic         tens_held;
    logic         sel_err;
    logic         sel_done;

    bingo_map_builder #(.CELLS(25)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_start  (sel_start),
        .one_num    (one_num),
        .enter_pulse(enter_pulse),
        .map        (map),
        .cell_idx   (cell_idx),
        .tens_held  (tens_held),
        .sel_err    (sel_err),
        .sel_done   (sel_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ok;
        logic [124:0] map;
        logic [4:0]   idx;
        logic         done;
    } exp_t;

    exp_t         sb_q[$];
    logic [124:0] m_map;
    logic [25:0]  m_used;
    int           m_cnt;
    int           n_chk;
    int           n_fail;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] d);
        one_num     = d;
        enter_pulse = 1'b1;
        tick();
        enter_pulse = 1'b0;
    endtask

    task automatic model_clear();
        m_map  = '0;
        m_used = '0;
        m_cnt  = 0;
    endtask

    task automatic start();
        sel_start = 1'b1;
        tick();
        sel_start = 1'b0;
        model_clear();
    endtask

    task automatic push_exp(input int num);
        exp_t e;
        e.ok = (num >= 1) && (num <= 25) && !m_used[num];
        if (e.ok) begin
            m_map[m_cnt*5 +: 5] = 5'(num);
            m_used[num] = 1'b1;
            m_cnt++;
        end
        e.map  = m_map;
        e.idx  = 5'(m_cnt);
        e.done = (m_cnt == 25);
        sb_q.push_back(e);
    endtask

    // Called right after the units strobe edge; consumes CHECK and one more cycle
    task automatic check_resp(input string tag);
        exp_t e;
        tick();
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 128'd1, 128'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_err"}, 128'(sel_err), 128'(!e.ok));
        check({tag, "_idx"}, 128'(cell_idx), 128'(e.idx));
        check({tag, "_map"}, 128'(map), 128'(e.map));
        check({tag, "_done"}, 128'(sel_done), 128'(e.done));
        tick();
        check({tag, "_errw"}, 128'(sel_err), 128'd0);
    endtask

    task automatic enter_num(input int t, input int u, input string tag);
        push_exp(t * 10 + u);
        strobe(4'(t));
        strobe(4'(u));
        check_resp(tag);
    endtask

    logic [124:0] saved;

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        sel_start   = 1'b0;
        enter_pulse = 1'b0;
        one_num     = '0;
        model_clear();

        tick();
        tick();
        check("rst_map", 128'(map), 128'd0);
        check("rst_idx", 128'(cell_idx), 128'd0);
        check("rst_th", 128'(tens_held), 128'd0);
        check("rst_err", 128'(sel_err), 128'd0);
        check("rst_done", 128'(sel_done), 128'd0);
        rst = 1'b0;
        tick();
        strobe(4'd1);
        check("idle_th", 128'(tens_held), 128'd0);
        check("idle_err", 128'(sel_err), 128'd0);
        tick();
        check("idle_map", 128'(map), 128'd0);

        start();
        for (int n = 1; n <= 25; n++) enter_num(n / 10, n % 10, "fill");
        check("fill_c0", 128'(map[4:0]), 128'd1);
        check("fill_c24", 128'(map[124:120]), 128'd25);
        check("fill_idx", 128'(cell_idx), 128'd25);
        check("fill_done", 128'(sel_done), 128'd1);

        saved = m_map;
        for (int k = 0; k < 5; k++) begin
            strobe(4'(k + 1));
            check("post_err", 128'(sel_err), 128'd0);
            tick();
            tick();
        end
        check("post_map", 128'(map), 128'(saved));
        check("post_done", 128'(sel_done), 128'd1);
        start();
        check("restart_done", 128'(sel_done), 128'd0);
        check("restart_map", 128'(map), 128'd0);

        enter_num(0, 0, "zero");
        enter_num(2, 6, "r26");
        strobe(4'hC);
        check("tensC_err", 128'(sel_err), 128'd1);
        check("tensC_th", 128'(tens_held), 128'd0);
        tick();
        check("tensC_errw", 128'(sel_err), 128'd0);
        tick();
        strobe(4'd0);
        check("t0_th", 128'(tens_held), 128'd1);
        tick();
        tick();
        strobe(4'hF);
        check("unitF_err", 128'(sel_err), 128'd1);
        check("unitF_th", 128'(tens_held), 128'd1);
        tick();
        tick();
        push_exp(3);
        strobe(4'd3);
        check_resp("keep_tens");

        start();
        enter_num(0, 7, "dup1");
        check("dup1_c0", 128'(map[4:0]), 128'd7);
        enter_num(0, 7, "dup2");
        check("dup2_c1", 128'(map[9:5]), 128'd0);
        check("dup2_idx", 128'(cell_idx), 128'd1);

        start();
        for (int n = 0; n < 10; n++) begin
            int v;
            v = (n * 7) % 25 + 1;
            enter_num(v / 10, v % 10, "part");
        end
        strobe(4'd1);
        check("part_th", 128'(tens_held), 128'd1);
        tick();
        tick();
        sel_start   = 1'b1;
        enter_pulse = 1'b1;
        one_num     = 4'd5;
        tick();
        sel_start   = 1'b0;
        enter_pulse = 1'b0;
        model_clear();
        check("rs_map", 128'(map), 128'd0);
        check("rs_idx", 128'(cell_idx), 128'd0);
        check("rs_th", 128'(tens_held), 128'd0);
        tick();
        tick();
        enter_num(0, 4, "rs_tens");

        strobe(4'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("mrst_th", 128'(tens_held), 128'd0);
        check("mrst_map", 128'(map), 128'd0);
        check("mrst_idx", 128'(cell_idx), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
